gf_poly_reduce_seq: RTL

//  Sequential GF(2) polynomial reducer and divider. Consumes the unreduced 2*(WIDTH-1)+1-bit

---
 rtl/gf_poly_reduce_seq.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/gf_poly_reduce_seq.sv
// ============================================================================
// gf_poly_reduce_seq
// ----------------------------------------------------------------------------
// Sequential GF(2) polynomial divider. It takes the unreduced carry-less
// product of two WIDTH-bit field elements (DW = 2*(WIDTH-1)+1 bits) and divides
// it by the field polynomial POLY, one dividend bit per clock, from the top
// bit down to bit WIDTH. The outputs are the WIDTH-bit remainder (the reduced
// field product) and the (WIDTH-1)-bit quotient.
//
// Ports
//   clk        in   1        rising-edge clock
//   rst        in   1        asynchronous active-high reset
//   in_valid   in   1        cin holds a dividend
//   in_ready   out  1        block is idle and will take cin
//   cin        in   DW       unreduced product, taken on in_valid && in_ready
//   out_valid  out  1        rem/quo hold a finished result
//   out_ready  in   1        downstream takes rem/quo
//   rem        out  WIDTH    cin mod POLY
//   quo        out  WIDTH-1  cin div POLY
//   busy       out  1        high while a division is running or unconsumed
//
// Optional build macro
//   GF_REDUCE_EARLY_EXIT_EN : when defined, a RUN cycle that finds every
//   remaining dividend bit at or above WIDTH already clear finishes at once,
//   so latency becomes 1..DW-WIDTH cycles. Results are unchanged. When not
//   defined, RUN always takes DW-WIDTH cycles and no leading-zero detect
//   logic exists.
// ============================================================================
module gf_poly_reduce_seq #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH:0]   POLY  = 9'h11B
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2*(WIDTH-1):0]      cin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          rem,
    output logic [WIDTH-2:0]          quo,
    output logic                      busy
);

    localparam int unsigned DW    = 2 * (WIDTH - 1) + 1;
    localparam int unsigned CNT_W = $clog2(DW);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // POLY zero-extended to the dividend width; shifting it left by at most
    // DW-1-WIDTH places keeps its top bit inside the DW-bit window.
    localparam logic [DW-1:0] POLY_EXT = DW'(POLY);

    state_t              state_q,     state_d;
    logic [DW-1:0]       acc_q,       acc_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic [WIDTH-1:0]    rem_q,       rem_d;
    logic [WIDTH-2:0]    quo_q,       quo_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q,      busy_d;

    logic [CNT_W-1:0]    shift_s;
    logic [DW-1:0]       poly_shift_s;
    logic [DW-1:0]       acc_step_s;
    logic                early_exit_s;

    // Polynomial aligned so that its leading term sits on bit cnt.
    always_comb begin
        shift_s      = cnt_q - CNT_W'(WIDTH);
        poly_shift_s = POLY_EXT << shift_s;
    end

    // One long-division step on the current bit: subtract (XOR) the aligned
    // polynomial when that bit is set, otherwise keep the accumulator.
    always_comb begin
        if (acc_q[cnt_q]) begin
            acc_step_s = acc_q ^ poly_shift_s;
        end else begin
            acc_step_s = acc_q;
        end
    end

`ifdef GF_REDUCE_EARLY_EXIT_EN
    // Leading-zero test: true when acc[cnt:WIDTH] is all zero, i.e. nothing
    // left to divide and the low WIDTH bits are already the remainder.
    always_comb begin
        early_exit_s = 1'b1;
        for (int j = WIDTH; j < DW; j++) begin
            if ((CNT_W'(j) <= cnt_q) && acc_q[j]) begin
                early_exit_s = 1'b0;
            end else begin
                early_exit_s = early_exit_s;
            end
        end
    end
`else
    // Fixed-length division: the early finish path is never taken.
    always_comb begin
        early_exit_s = 1'b0;
    end
`endif

    // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    acc_d   = cin;
                    quo_d   = '0;
                    cnt_d   = CNT_W'(DW - 1);
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                if (early_exit_s) begin
                    // Remaining quotient bits were cleared on accept.
                    rem_d       = acc_q[WIDTH-1:0];
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    acc_d = acc_step_s;
                    for (int q = 0; q < WIDTH - 1; q++) begin
                        if ((cnt_q == CNT_W'(q + WIDTH)) && acc_q[cnt_q]) begin
                            quo_d[q] = 1'b1;
                        end else begin
                            quo_d[q] = quo_q[q];
                        end
                    end
                    if (cnt_q == CNT_W'(WIDTH)) begin
                        // Last step: the low bits of the updated accumulator
                        // are the remainder.
                        rem_d       = acc_step_s[WIDTH-1:0];
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        cnt_d   = cnt_q - CNT_W'(1);
                        state_d = ST_RUN;
                    end
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end

            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers; reset discards any in-flight division.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= CNT_W'(DW - 1);
            rem_q       <= '0;
            quo_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Output mapping; in_ready is a decode of the state so it is high in reset.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = out_valid_q;
        rem       = rem_q;
        quo       = quo_q;
        busy      = busy_q;
    end

endmodule
